// File: rtl/id_ex_stage_pkg.sv
// Shared core types for the ID/EX boundary: widths, ALU op codes
// and the packed ID->EX bundle together with its bubble encoding.
package id_ex_stage_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN-1:0]    rd1;
        logic [XLEN-1:0]    rd2;
        logic [XLEN-1:0]    imm;
        logic               reg_we;
        logic               mem_re;
        logic               mem_we;
        logic [ALUOP_W-1:0] alu_op;
        logic               valid;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: a load sitting in EX whose destination
// is read by the live instruction in ID. A load to x0 never matches.
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_re,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_valid & i_ex_mem_re & (i_ex_rd != 5'd0) &
                        i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, redirect
// flush, busy hold and saturating hazard event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [XLEN-1:0]    id_rd1,
    input  logic [XLEN-1:0]    id_rd2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_reg_we,
    input  logic               id_mem_re,
    input  logic               id_mem_we,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               ex_busy,
    input  logic               ex_redirect,
    output logic               ex_valid,
    output logic [XLEN-1:0]    pc_e,
    output logic [4:0]         rs1e,
    output logic [4:0]         rs2e,
    output logic [4:0]         rde,
    output logic [XLEN-1:0]    rd1e,
    output logic [XLEN-1:0]    rd2e,
    output logic [XLEN-1:0]    imme,
    output logic               reg_wee,
    output logic               mem_ree,
    output logic               mem_wee,
    output logic [ALUOP_W-1:0] alu_ope,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic [CNT_W-1:0]   lu_bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    id_ex_t           r_q;
    id_ex_t           w_id;
    logic             w_load_use;
    logic             w_flush;
    logic             w_lu;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_fl_cnt;

    load_use_detect u_lud (
        .i_ex_valid    (r_q.valid),
        .i_ex_mem_re   (r_q.mem_re),
        .i_ex_rd       (r_q.rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    always_comb begin
        w_id        = ID_EX_BUBBLE;
        w_id.pc     = id_pc;
        w_id.rs1    = id_rs1;
        w_id.rs2    = id_rs2;
        w_id.rd     = id_rd;
        w_id.rd1    = id_rd1;
        w_id.rd2    = id_rd2;
        w_id.imm    = id_imm;
        w_id.reg_we = id_reg_we;
        w_id.mem_re = id_mem_re;
        w_id.mem_we = id_mem_we;
        w_id.alu_op = id_alu_op;
        w_id.valid  = id_valid;
    end

    // busy outranks redirect, which outranks load-use
    assign w_flush = ~rst & ~ex_busy & ex_redirect;
    assign w_lu    = ~rst & ~ex_busy & ~ex_redirect & w_load_use;
    assign stall_f = ~rst & (ex_busy | w_lu);
    assign stall_d = stall_f;
    assign flush_d = w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= ID_EX_BUBBLE;
            r_lu_cnt <= '0;
            r_fl_cnt <= '0;
        end else if (!ex_busy) begin
            if (w_flush || w_lu || !id_valid) begin
                r_q <= ID_EX_BUBBLE;
            end else begin
                r_q <= w_id;
            end
            if (w_lu && !(&r_lu_cnt)) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
            if (w_flush && !(&r_fl_cnt)) begin
                r_fl_cnt <= r_fl_cnt + 1'b1;
            end
        end
    end

    assign ex_valid      = r_q.valid;
    assign pc_e          = r_q.pc;
    assign rs1e          = r_q.rs1;
    assign rs2e          = r_q.rs2;
    assign rde           = r_q.rd;
    assign rd1e          = r_q.rd1;
    assign rd2e          = r_q.rd2;
    assign imme          = r_q.imm;
    assign reg_wee       = r_q.reg_we;
    assign mem_ree       = r_q.mem_re;
    assign mem_wee       = r_q.mem_we;
    assign alu_ope       = r_q.alu_op;
    assign lu_bubble_cnt = r_lu_cnt;
    assign flush_cnt     = r_fl_cnt;

endmodule
